// File: rtl/turbo_addr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : turbo_addr_seq_ctrl_if
//  Purpose  : Bundles the request/configuration inputs and the sequencing
//             outputs of the turbo address sequencer into one interface.
//  Modports : master - block requester (drives start/abort/win_len/num_win,
//                      observes the sequencing outputs)
//             slave  - the sequencer itself
//  Signals  : start, abort, win_len[AW], num_win[WW]          (to sequencer)
//             init_flag, cmp_direction, init_sel, win_idx[WW],
//             addr_valid, step_idx[AW], busy, done, cfg_err   (from sequencer)
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef Data_Addr_width
`define Data_Addr_width 8
`endif

interface turbo_addr_seq_ctrl_if #(
    parameter int AW = `Data_Addr_width,
    parameter int WW = 6
);
    logic          start;
    logic          abort;
    logic [AW-1:0] win_len;
    logic [WW-1:0] num_win;
    logic          init_flag;
    logic          cmp_direction;
    logic          init_sel;
    logic [WW-1:0] win_idx;
    logic          addr_valid;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          done;
    logic          cfg_err;

    modport master (
        output start, abort, win_len, num_win,
        input  init_flag, cmp_direction, init_sel, win_idx,
               addr_valid, step_idx, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, win_len, num_win,
        output init_flag, cmp_direction, init_sel, win_idx,
               addr_valid, step_idx, busy, done, cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/turbo_addr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : turbo_addr_seq_ctrl
//  Purpose  : Sequences a windowed turbo-decoder address calculator. For each
//             window it issues an init cycle (window start), win_len forward
//             steps, an init cycle (window end) and win_len backward steps,
//             then moves to the next window; a one-cycle DONE ends the block.
//  Ports    : clk   - single clock, rising edge
//             reset - synchronous, active-high
//             bus   - turbo_addr_seq_ctrl_if.slave (start/abort/config in,
//                     calculator control and status out)
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef Data_Addr_width
`define Data_Addr_width 8
`endif

module turbo_addr_seq_ctrl #(
    parameter int AW = `Data_Addr_width,
    parameter int WW = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    turbo_addr_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_F = 3'd1,
        FWD    = 3'd2,
        INIT_B = 3'd3,
        BWD    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [AW-1:0] c_AW_ONE = 1;
    localparam logic [WW-1:0] c_WW_ONE = 1;

    state_t        r_state;
    logic [AW-1:0] r_winLen;
    logic [WW-1:0] r_numWin;
    logic [WW-1:0] r_winIdx;
    logic [AW-1:0] r_stepIdx;
    logic          r_initFlag;
    logic          r_cmpDir;
    logic          r_initSel;
    logic          r_addrValid;
    logic          r_busy;
    logic          r_done;
    logic          r_cfgErr;

    // Both decoded only from latched/registered values; win_len and num_win
    // are nonzero whenever these are used, so the subtractions never wrap.
    logic w_lastFwd;
    logic w_moreWin;
    assign w_lastFwd = (r_stepIdx == (r_winLen - c_AW_ONE));
    assign w_moreWin = (r_winIdx < (r_numWin - c_WW_ONE));

    // Outputs are registered together with the state transition: every
    // branch that enters a state also loads that state's output values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_winLen    <= '0;
            r_numWin    <= '0;
            r_winIdx    <= '0;
            r_stepIdx   <= '0;
            r_initFlag  <= 1'b0;
            r_cmpDir    <= 1'b1;
            r_initSel   <= 1'b0;
            r_addrValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfgErr    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_cfgErr <= 1'b0;
            if (bus.abort) begin
                r_state     <= IDLE;
                r_initFlag  <= 1'b0;
                r_cmpDir    <= 1'b1;
                r_initSel   <= 1'b0;
                r_addrValid <= 1'b0;
                r_stepIdx   <= '0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            if ((bus.win_len != '0) && (bus.num_win != '0)) begin
                                r_winLen   <= bus.win_len;
                                r_numWin   <= bus.num_win;
                                r_winIdx   <= '0;
                                r_state    <= INIT_F;
                                r_initFlag <= 1'b1;
                                r_initSel  <= 1'b0;
                                r_cmpDir   <= 1'b1;
                                r_busy     <= 1'b1;
                            end else begin
                                r_cfgErr <= 1'b1;
                            end
                        end
                    end
                    INIT_F: begin
                        r_state     <= FWD;
                        r_initFlag  <= 1'b0;
                        r_addrValid <= 1'b1;
                        r_stepIdx   <= '0;
                    end
                    FWD: begin
                        if (w_lastFwd) begin
                            r_state     <= INIT_B;
                            r_addrValid <= 1'b0;
                            r_stepIdx   <= '0;
                            r_initFlag  <= 1'b1;
                            r_initSel   <= 1'b1;
                            r_cmpDir    <= 1'b0;
                        end else begin
                            r_stepIdx <= r_stepIdx + c_AW_ONE;
                        end
                    end
                    INIT_B: begin
                        r_state     <= BWD;
                        r_initFlag  <= 1'b0;
                        r_initSel   <= 1'b0;
                        r_addrValid <= 1'b1;
                        r_stepIdx   <= r_winLen - c_AW_ONE;
                    end
                    BWD: begin
                        if (r_stepIdx == '0) begin
                            r_addrValid <= 1'b0;
                            r_cmpDir    <= 1'b1;
                            if (w_moreWin) begin
                                r_winIdx   <= r_winIdx + c_WW_ONE;
                                r_state    <= INIT_F;
                                r_initFlag <= 1'b1;
                                r_initSel  <= 1'b0;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_stepIdx <= r_stepIdx - c_AW_ONE;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_initFlag  <= 1'b0;
                        r_cmpDir    <= 1'b1;
                        r_initSel   <= 1'b0;
                        r_addrValid <= 1'b0;
                        r_stepIdx   <= '0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.init_flag     = r_initFlag;
    assign bus.cmp_direction = r_cmpDir;
    assign bus.init_sel      = r_initSel;
    assign bus.win_idx       = r_winIdx;
    assign bus.addr_valid    = r_addrValid;
    assign bus.step_idx      = r_stepIdx;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.cfg_err       = r_cfgErr;

endmodule

`default_nettype wire

// File: tb/tb_turbo_addr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_turbo_addr_seq_ctrl
//  Purpose  : Self-checking bench for turbo_addr_seq_ctrl. A table of block
//             configurations is run against a cycle-by-cycle expected output
//             sequence built from nested window/step loops, plus hand-written
//             sequences for reset, abort and start-while-busy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_turbo_addr_seq_ctrl;

    localparam int AW = 4;
    localparam int WW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    turbo_addr_seq_ctrl_if #(.AW(AW), .WW(WW)) bus ();

    turbo_addr_seq_ctrl #(.AW(AW), .WW(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          initF;
        logic          dir;
        logic          selCare;
        logic          sel;
        logic          widxCare;
        logic [WW-1:0] widx;
        logic          av;
        logic [AW-1:0] sidx;
        logic          busy;
        logic          done;
        logic          cfgErr;
    } exp_t;

    typedef struct {
        int    winLen;
        int    numWin;
        int    expBusy;
        int    expInit;
        int    expErr;
        string name;
    } vec_t;

    int   nChecks = 0;
    int   nFails  = 0;
    exp_t q[$];
    vec_t vecs[7];

    function automatic exp_t mk(logic initF, logic dir, logic selCare, logic sel,
                                logic widxCare, int widx, logic av, int sidx,
                                logic busy, logic done, logic cfgErr);
        exp_t e;
        e.initF    = initF;
        e.dir      = dir;
        e.selCare  = selCare;
        e.sel      = sel;
        e.widxCare = widxCare;
        e.widx     = WW'(widx);
        e.av       = av;
        e.sidx     = AW'(sidx);
        e.busy     = busy;
        e.done     = done;
        e.cfgErr   = cfgErr;
        return e;
    endfunction

    task automatic check_cycle(input exp_t e, input string tag);
        logic ok;
        ok = (bus.init_flag === e.initF) && (bus.cmp_direction === e.dir) &&
             (!e.selCare || (bus.init_sel === e.sel)) &&
             (!e.widxCare || (bus.win_idx === e.widx)) &&
             (bus.addr_valid === e.av) && (bus.step_idx === e.sidx) &&
             (bus.busy === e.busy) && (bus.done === e.done) &&
             (bus.cfg_err === e.cfgErr);
        nChecks++;
        if (!ok) begin
            nFails++;
            $display("FAIL %s @%0t: got init=%b dir=%b sel=%b widx=%0d av=%b step=%0d busy=%b done=%b err=%b; want init=%b dir=%b sel=%b(care %b) widx=%0d(care %b) av=%b step=%0d busy=%b done=%b err=%b",
                     tag, $time, bus.init_flag, bus.cmp_direction, bus.init_sel, bus.win_idx,
                     bus.addr_valid, bus.step_idx, bus.busy, bus.done, bus.cfg_err,
                     e.initF, e.dir, e.sel, e.selCare, e.widx, e.widxCare, e.av, e.sidx,
                     e.busy, e.done, e.cfgErr);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        nChecks++;
        if (got != want) begin
            nFails++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Expected output sequence, starting with the cycle after start is sampled
    // and ending with one idle cycle.
    task automatic build_q(input int L, input int N);
        q.delete();
        if (L == 0 || N == 0) begin
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            for (int w = 0; w < N; w++) begin
                q.push_back(mk(1, 1, 1, 0, 1, w, 0, 0, 1, 0, 0));
                for (int s = 0; s < L; s++)
                    q.push_back(mk(0, 1, 0, 0, 1, w, 1, s, 1, 0, 0));
                q.push_back(mk(1, 0, 1, 1, 1, w, 0, 0, 1, 0, 0));
                for (int s = L - 1; s >= 0; s--)
                    q.push_back(mk(0, 0, 0, 0, 1, w, 1, s, 1, 0, 0));
            end
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        end
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Pulses (or holds) start and compares every following cycle with the
    // expected sequence. The config inputs are scrambled after start so that
    // only the latched values can produce the right sequence. A nonzero
    // stopAfter returns with the DUT sitting in expected entry stopAfter.
    task automatic run_block(input int L, input int N, input bit hold,
                             input int stopAfter, input string tag,
                             output int busyCnt, output int initCnt, output int errCnt);
        build_q(L, N);
        busyCnt = 0;
        initCnt = 0;
        errCnt  = 0;
        bus.win_len = AW'(L);
        bus.num_win = WW'(N);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        bus.win_len = '0;
        bus.num_win = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (stopAfter > 0 && i == stopAfter) break;
            check_cycle(q[i], tag);
            busyCnt += int'(bus.busy);
            initCnt += int'(bus.init_flag);
            errCnt  += int'(bus.cfg_err);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t eReset;
        exp_t eIdle;
        int   b;
        int   ini;
        int   err;

        vecs[0] = '{4,  1, 11,  2, 0, "wl4_nw1"};
        vecs[1] = '{2,  3, 19,  6, 0, "wl2_nw3"};
        vecs[2] = '{1,  1,  5,  2, 0, "wl1_nw1"};
        vecs[3] = '{15, 7, 225, 14, 0, "wlmax_nwmax"};
        vecs[4] = '{0,  2,  0,  0, 1, "wl0_cfgerr"};
        vecs[5] = '{3,  0,  0,  0, 1, "nw0_cfgerr"};
        vecs[6] = '{3,  2, 17,  4, 0, "wl3_nw2"};

        eReset = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        eIdle  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.win_len = '0;
        bus.num_win = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cycle(eReset, "reset_state");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            run_block(vecs[v].winLen, vecs[v].numWin, 1'b0, 0, vecs[v].name, b, ini, err);
            chk_int({vecs[v].name, "_busy_cycles"}, b, vecs[v].expBusy);
            chk_int({vecs[v].name, "_init_cycles"}, ini, vecs[v].expInit);
            chk_int({vecs[v].name, "_cfg_err"}, err, vecs[v].expErr);
        end

        // Abort during the third forward step.
        run_block(4, 1, 1'b0, 3, "abort_pre", b, ini, err);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_cycle(eIdle, "abort_to_idle");
        for (int i = 0; i < 3; i++) begin
            check_cycle(eIdle, "abort_no_done");
            @(posedge clk); #1;
        end

        // Abort together with start in IDLE must not launch a block.
        bus.win_len = AW'(4);
        bus.num_win = WW'(1);
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_cycle(eIdle, "abort_with_start");
        @(posedge clk); #1;
        check_cycle(eIdle, "abort_with_start_2");

        run_block(4, 1, 1'b0, 0, "after_abort", b, ini, err);
        chk_int("after_abort_busy_cycles", b, 11);

        // start held high (and config changed) while busy, then reset in BWD.
        run_block(3, 2, 1'b1, 6, "hold_start", b, ini, err);
        chk_int("hold_start_busy_so_far", b, 6);
        reset = 1'b1;
        @(posedge clk); #1;
        check_cycle(eReset, "reset_in_bwd");
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        check_cycle(eReset, "idle_after_reset");

        run_block(3, 2, 1'b0, 0, "after_reset", b, ini, err);
        chk_int("after_reset_busy_cycles", b, 17);
        chk_int("after_reset_init_cycles", ini, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/turbo_addr_seq_ctrl.md
TURBO_ADDR_SEQ_CTRL -- requirements
Module: turbo_addr_seq_ctrl

Interface
REQ-001 Parameter: AW, default `Data_Addr_width; width of window-length counters and step index.
REQ-002 Parameter: WW, default 6; width of the window count and window index.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  one-cycle request to begin a block; sampled only in IDLE.
REQ-006 Port: abort  in  1  terminates the block; has priority over every other input except reset.
REQ-007 Port: win_len  in  AW  steps per window per direction; latched at accepted start.
REQ-008 Port: num_win  in  WW  windows per block; latched at accepted start.
REQ-009 Port: init_flag  out  1  drives the address calculator's initialisation input.
REQ-010 Port: cmp_direction  out  1  drives the calculator direction: 1 = forward step, 0 = backward step.
REQ-011 Port: init_sel  out  1  selects the initial-value set in the init cycle: 0 = window start (forward), 1 = window end (backward).
REQ-012 Port: win_idx  out  WW  index of the current window.
REQ-013 Port: addr_valid  out  1  the calculator output is a live address this cycle.
REQ-014 Port: step_idx  out  AW  position of the live address within the window pass.
REQ-015 Port: busy  out  1  high in every state except IDLE.
REQ-016 Port: done  out  1  one-cycle pulse on normal block completion.
REQ-017 Port: cfg_err  out  1  one-cycle pulse when start is rejected for an illegal configuration.

Function
REQ-018 FSM states SHALL be IDLE, INIT_F, FWD, INIT_B, BWD and DONE; the encoding is free.
REQ-019 In IDLE, start=1 with win_len!=0 and num_win!=0 SHALL latch the configuration, clear win_idx, and go to INIT_F.
REQ-020 In IDLE, start=1 with win_len==0 or num_win==0 SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-021 INIT_F SHALL last 1 cycle with init_flag=1, init_sel=0, cmp_direction=1 and addr_valid=0, then go to FWD.
REQ-022 FWD SHALL last exactly win_len cycles with cmp_direction=1, addr_valid=1, and step_idx counting 0..win_len-1; it then goes to INIT_B.
REQ-023 INIT_B SHALL last 1 cycle with init_flag=1, init_sel=1, cmp_direction=0 and addr_valid=0, then go to BWD.
REQ-024 BWD SHALL last exactly win_len cycles with cmp_direction=0, addr_valid=1, and step_idx counting win_len-1 down to 0.
REQ-025 At the end of BWD: if win_idx < num_win-1, win_idx SHALL increment and the FSM goes to INIT_F; otherwise it goes to DONE.
REQ-026 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-027 Address latency is 1 cycle: the address loaded in an INIT cycle is presented in the first FWD/BWD cycle, and each step cycle advances the calculator for the next cycle.
REQ-028 Per block, the total busy cycles SHALL equal num_win*(2*win_len+2)+1.
REQ-029 Counter arithmetic is unsigned at AW/WW bits; win_len = 2^AW-1 and num_win = 2^WW-1 SHALL run without wrap or early exit.
REQ-030 start while busy SHALL be ignored, with no effect on state or latched configuration.
REQ-031 abort=1 in any state SHALL force IDLE on the next edge with no done pulse; abort=1 together with start in IDLE SHALL leave the FSM in IDLE.
REQ-032 Outside FWD/BWD, addr_valid SHALL be 0 and step_idx SHALL be 0; init_flag SHALL be 0 outside INIT_F/INIT_B.
REQ-033 In IDLE and DONE, cmp_direction SHALL be 1.
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE in any state, including mid-pass.
REQ-036 On reset, init_flag=0, cmp_direction=1, init_sel=0, win_idx=0, addr_valid=0, step_idx=0, busy=0, done=0 and cfg_err=0.
REQ-037 Reset SHALL clear the latched win_len and num_win to 0.
REQ-038 reset SHALL take priority over abort and start.

Verification
REQ-039 Scenario: win_len=4, num_win=1, start -> INIT_F, 4 FWD cycles (step_idx 0,1,2,3), INIT_B, 4 BWD cycles (step_idx 3,2,1,0), done pulse; busy high for 11 cycles.
REQ-040 Scenario: win_len=2, num_win=3 -> win_idx sequence 0,1,2; done after 19 busy cycles; init_flag high in exactly 6 cycles.
REQ-041 Scenario: start with win_len=0 -> cfg_err pulse the next cycle; busy stays 0.
REQ-042 Scenario: abort in the 3rd FWD cycle -> IDLE next cycle, addr_valid=0, no done; a new start then runs normally from win_idx=0.
REQ-043 Scenario: reset asserted in BWD, plus start held high during busy -> IDLE with all reset values; start during busy has no effect on step count.
REQ-044 Scenario: win_len=1, num_win=1 -> FWD and BWD each last 1 cycle with step_idx=0; busy for 5 cycles.
